// File: rtl/bus_dma_master_pkg.sv
// Shared types and constants for the bus DMA master: FSM state encoding,
// word stride and the memory-mapped I/O address map.
package bus_dma_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_FIN  = 3'd4
  } dma_state_t;

  localparam int WORDBYTES = 4;

  localparam logic [31:0] ADDRHEX  = 32'hFFFF_F000;
  localparam logic [31:0] ADDRLEDR = 32'hFFFF_F020;
  localparam logic [31:0] ADDRKEY  = 32'hFFFF_F080;
  localparam logic [31:0] ADDRSW   = 32'hFFFF_F090;
  localparam logic [31:0] ADDRTCNT = 32'hFFFF_F100;
  localparam logic [31:0] ADDRTLIM = 32'hFFFF_F104;
  localparam logic [31:0] ADDRTCTL = 32'hFFFF_F108;

endpackage

// File: rtl/bus_dma_master.sv
// Word-copy bus initiator: one read then one write per word, 2 cycles/word once granted.
// Waits in REQ while grant is low; grant is re-checked only after each write so pairs never split.
module bus_dma_master
  import bus_dma_master_pkg::*;
#(
  parameter int DBITS     = 32,
  parameter int CNTBITS   = 16,
  parameter int WORDBYTES = bus_dma_master_pkg::WORDBYTES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DBITS-1:0]   src_addr,
  input  logic [DBITS-1:0]   dst_addr,
  input  logic [CNTBITS-1:0] word_cnt,
  input  logic               abort,
  input  logic               bus_gnt,
  output logic               bus_req,
  output logic               bus_own,
  output logic [DBITS-1:0]   abus,
  output logic               we,
  inout  wire  [DBITS-1:0]   dbus,
  output logic               busy,
  output logic               done,
  output logic               aborted
);

  localparam logic [DBITS-1:0]   ADDR_INC   = DBITS'(WORDBYTES);
  localparam logic [DBITS-1:0]   ALIGN_MASK = DBITS'(WORDBYTES - 1);
  localparam logic [CNTBITS-1:0] CNT_ONE    = CNTBITS'(1);

  dma_state_t         state, state_nxt;
  logic [DBITS-1:0]   src_q, dst_q, data_q;
  logic [CNTBITS-1:0] rem_q;
  logic               aborted_q;
  logic               cancel;

  // Abort only has meaning while a transfer (or its FIN cycle) is in flight.
  assign cancel = abort && (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      data_q    <= '0;
      rem_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cancel) begin
        aborted_q <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            src_q     <= src_addr & ~ALIGN_MASK;
            dst_q     <= dst_addr & ~ALIGN_MASK;
            rem_q     <= word_cnt;
            aborted_q <= 1'b0;
          end
        end
        ST_RD: begin
          data_q <= dbus;
        end
        ST_WR: begin
          src_q <= src_q + ADDR_INC;
          dst_q <= dst_q + ADDR_INC;
          rem_q <= rem_q - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = (word_cnt != '0) ? ST_REQ : ST_FIN;
        end
      end
      ST_REQ: begin
        if (abort)        state_nxt = ST_IDLE;
        else if (bus_gnt) state_nxt = ST_RD;
      end
      ST_RD: begin
        state_nxt = abort ? ST_IDLE : ST_WR;
      end
      ST_WR: begin
        // The write itself commits on this edge even when aborting.
        if (abort)                 state_nxt = ST_IDLE;
        else if (rem_q == CNT_ONE) state_nxt = ST_FIN;
        else if (bus_gnt)          state_nxt = ST_RD;
        else                       state_nxt = ST_REQ;
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    bus_req = 1'b0;
    bus_own = 1'b0;
    abus    = '0;
    we      = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      ST_REQ: begin
        bus_req = 1'b1;
        busy    = 1'b1;
      end
      ST_RD: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        bus_own = 1'b1;
        abus    = src_q;
      end
      ST_WR: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        bus_own = 1'b1;
        abus    = dst_q;
        we      = 1'b1;
      end
      ST_FIN: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign aborted = aborted_q;
  assign dbus    = we ? data_q : 'z;

endmodule
